// File: rtl/exception_arbiter.sv
// -----------------------------------------------------------------------------
// exception_arbiter
//   Sits in front of the CP0 register file. It takes the exception flags of the
//   MEM-stage instruction and the interrupt state read back from CP0. It picks
//   one winner by fixed priority. It then issues a single-cycle CP0 exception
//   write, or an EXL clear for ERET, together with a PC redirect. After that it
//   holds the pipeline flush for FLUSH_CYCLES more cycles.
//
// Ports
//   clk_i, rst_ni          clock (rising edge), synchronous active-low reset
//   mem_valid_i            a real instruction occupies MEM
//   mem_pc_i, mem_bd_i     PC / branch-delay flag of the MEM instruction
//   mem_addr_i             load/store effective address
//   exc_req_i[6:0]         AdEL-fetch, RI, Ov, Sys, Bp, AdEL-load, AdES
//   eret_i                 MEM instruction is ERET
//   status_data_i          CP0 Status (IM=[15:8], EXL=[1], IE=[0])
//   cause_data_i           CP0 Cause  (IP=[15:8])
//   epc_data_i             CP0 EPC (ERET target)
//   cp0_exc_we_o           pulse: write EPC/ExcCode/BD (+BadVAddr if badv_we)
//   cp0_badv_we_o          qualifies the BadVAddr write
//   cp0_epc_o, cp0_badvaddr_o, cp0_exc_code_o, cp0_bd_o   CP0 write data
//   cp0_exl_clr_o          pulse: clear Status.EXL
//   flush_o                kill IF..MEM
//   redirect_valid_o       pulse: load redirect_pc_o into the PC
//   redirect_pc_o          new fetch address
//   busy_o                 arbiter is not IDLE; upstream holds
// -----------------------------------------------------------------------------
module exception_arbiter #(
    parameter int               WIDTH        = 32,
    parameter logic [WIDTH-1:0] EXC_VECTOR   = 32'hBFC00380,
    parameter int               FLUSH_CYCLES = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             mem_valid_i,
    input  logic [WIDTH-1:0] mem_pc_i,
    input  logic             mem_bd_i,
    input  logic [WIDTH-1:0] mem_addr_i,
    input  logic [6:0]       exc_req_i,
    input  logic             eret_i,
    input  logic [WIDTH-1:0] status_data_i,
    input  logic [WIDTH-1:0] cause_data_i,
    input  logic [WIDTH-1:0] epc_data_i,
    output logic             cp0_exc_we_o,
    output logic             cp0_badv_we_o,
    output logic [WIDTH-1:0] cp0_epc_o,
    output logic [WIDTH-1:0] cp0_badvaddr_o,
    output logic [4:0]       cp0_exc_code_o,
    output logic             cp0_bd_o,
    output logic             cp0_exl_clr_o,
    output logic             flush_o,
    output logic             redirect_valid_o,
    output logic [WIDTH-1:0] redirect_pc_o,
    output logic             busy_o
);

    typedef enum logic [1:0] {IDLE, COMMIT, FLUSH} state_e;

    // Winner of the current MEM instruction, resolved combinationally
    typedef struct packed {
        logic             is_exc;   // 0: ERET won
        logic [4:0]       code;
        logic             badv_we;
        logic [WIDTH-1:0] badv;
    } winner_t;

    state_e           state_q;
    logic [3:0]       flush_cnt_q;
    logic             exc_we_q, badv_we_q, exl_clr_q, flush_q, rvalid_q, busy_q, bd_q;
    logic [WIDTH-1:0] epc_q, badv_q, rpc_q;
    logic [4:0]       code_q;

    logic             int_pend;
    logic             take_d;
    logic [WIDTH-1:0] epc_d;
    winner_t          win_d;

    // Interrupts are masked while EXL=1 or IE=0
    assign int_pend = (|(status_data_i[15:8] & cause_data_i[15:8]))
                      & status_data_i[0] & ~status_data_i[1];
    assign take_d   = mem_valid_i & (int_pend | (|exc_req_i) | eret_i);
    assign epc_d    = mem_bd_i ? mem_pc_i - WIDTH'(4) : mem_pc_i;

    always_comb begin
        win_d = '{is_exc: 1'b1, code: 5'd0, badv_we: 1'b0, badv: mem_addr_i};
        if (int_pend)          win_d.code = 5'd0;
        else if (exc_req_i[0]) begin
            win_d.code    = 5'd4;
            win_d.badv_we = 1'b1;
            win_d.badv    = mem_pc_i;
        end
        else if (exc_req_i[1]) win_d.code = 5'd10;
        else if (exc_req_i[2]) win_d.code = 5'd12;
        else if (exc_req_i[3]) win_d.code = 5'd8;
        else if (exc_req_i[4]) win_d.code = 5'd9;
        else if (exc_req_i[5]) begin
            win_d.code    = 5'd4;
            win_d.badv_we = 1'b1;
        end
        else if (exc_req_i[6]) begin
            win_d.code    = 5'd5;
            win_d.badv_we = 1'b1;
        end
        else                   win_d.is_exc = 1'b0;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            flush_cnt_q <= '0;
            exc_we_q    <= 1'b0;
            badv_we_q   <= 1'b0;
            exl_clr_q   <= 1'b0;
            flush_q     <= 1'b0;
            rvalid_q    <= 1'b0;
            busy_q      <= 1'b0;
            bd_q        <= 1'b0;
            epc_q       <= '0;
            badv_q      <= '0;
            rpc_q       <= '0;
            code_q      <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (take_d) begin
                        state_q  <= COMMIT;
                        busy_q   <= 1'b1;
                        flush_q  <= 1'b1;
                        rvalid_q <= 1'b1;
                        if (win_d.is_exc) begin
                            exc_we_q  <= 1'b1;
                            badv_we_q <= win_d.badv_we;
                            code_q    <= win_d.code;
                            badv_q    <= win_d.badv;
                            epc_q     <= epc_d;
                            bd_q      <= mem_bd_i;
                            rpc_q     <= EXC_VECTOR;
                        end else begin
                            exl_clr_q <= 1'b1;
                            rpc_q     <= epc_data_i;
                        end
                    end
                end
                COMMIT: begin
                    // Pulses last exactly the COMMIT cycle; flush stays up
                    state_q     <= FLUSH;
                    exc_we_q    <= 1'b0;
                    badv_we_q   <= 1'b0;
                    exl_clr_q   <= 1'b0;
                    rvalid_q    <= 1'b0;
                    flush_cnt_q <= 4'd1;
                end
                FLUSH: begin
                    if (flush_cnt_q == 4'(FLUSH_CYCLES)) begin
                        state_q     <= IDLE;
                        flush_cnt_q <= '0;
                        flush_q     <= 1'b0;
                        busy_q      <= 1'b0;
                    end else begin
                        flush_cnt_q <= flush_cnt_q + 4'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign cp0_exc_we_o     = exc_we_q;
    assign cp0_badv_we_o    = badv_we_q;
    assign cp0_epc_o        = epc_q;
    assign cp0_badvaddr_o   = badv_q;
    assign cp0_exc_code_o   = code_q;
    assign cp0_bd_o         = bd_q;
    assign cp0_exl_clr_o    = exl_clr_q;
    assign flush_o          = flush_q;
    assign redirect_valid_o = rvalid_q;
    assign redirect_pc_o    = rpc_q;
    assign busy_o           = busy_q;

endmodule
